gpsdo_loop_ctrl: RTL and testbench

Sequences the GPSDO frequency counter and closes the OCXO disciplining loop.
- Drives the counter's RUN, CLR and MULT (gate length) controls.
- Consumes each DIFF/RDY measurement and updates a 16-bit OCXO tuning DAC word.
- Moves from a short-gate coarse acquire mode to a long-gate fine track mode, and falls back to holdover when GPS or measurements are lost.
- Sits between the counter and the DAC serialiser, in the CLK domain.

---
 rtl/gpsdo_pkg.sv | 18 +
 rtl/sync_rise.sv | 21 ++
 rtl/gpsdo_loop_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_gpsdo_loop_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gpsdo_pkg.sv
// Shared encodings and constants for the GPSDO loop controller.
package gpsdo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_ACQUIRE  = 3'd2,
    ST_TRACK    = 3'd3,
    ST_HOLDOVER = 3'd4
  } state_t;

  localparam logic [15:0] DIFF_ZERO = 16'h7FFF;
  localparam logic [15:0] DAC_MIN   = 16'h0000;
  localparam logic [15:0] DAC_MAX   = 16'hFFFF;
  localparam int          ERR_W     = 17;
  localparam int          ACC_W     = 19;

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchroniser with a registered rising-edge pulse (3 cycles after the input edge).
module sync_rise (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [2:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh   <= 3'b000;
      rise <= 1'b0;
    end else begin
      sh   <= {sh[1:0], din};
      rise <= sh[1] & ~sh[2];
    end
  end

endmodule

// File: rtl/gpsdo_loop_ctrl.sv
// GPSDO loop controller: sequences the frequency counter and steers the OCXO tuning DAC
// through coarse acquire, fine track and holdover modes.
module gpsdo_loop_ctrl
  import gpsdo_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 10_000_000,
  parameter logic [7:0]  MULT_COARSE = 8'd0,
  parameter logic [7:0]  MULT_FINE   = 8'd15,
  parameter int          LOCK_THR    = 2,
  parameter int unsigned LOCK_CNT    = 8,
  parameter int          UNLOCK_THR  = 20,
  parameter int unsigned KC_SHIFT    = 2,
  parameter int unsigned KF_SHIFT    = 1,
  parameter logic [15:0] DAC_INIT    = 16'h8000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic        PPS_VALID,
  input  logic        PPS,
  input  logic [15:0] DIFF,
  input  logic        RDY,
  output logic        RUN,
  output logic        CLR,
  output logic [7:0]  MULT,
  output logic [15:0] DAC_WORD,
  output logic        DAC_LOAD,
  output logic        LOCKED,
  output logic [2:0]  STATE
);

  localparam logic [31:0]             PRESC_MAX  = 32'(CLK_HZ - 1);
  localparam logic [7:0]              LOCK_N     = 8'(LOCK_CNT);
  localparam logic signed [ERR_W-1:0] LOCK_POS   = ERR_W'(LOCK_THR);
  localparam logic signed [ERR_W-1:0] LOCK_NEG   = -LOCK_POS;
  localparam logic signed [ERR_W-1:0] UNLOCK_POS = ERR_W'(UNLOCK_THR);
  localparam logic signed [ERR_W-1:0] UNLOCK_NEG = -UNLOCK_POS;
  // Holdover dwells at least one full tick before re-arming the counter.
  localparam logic [9:0]              HOLD_TICKS = 10'd1;
  localparam logic [9:0]              CLR_TICKS  = 10'd2;

  function automatic logic [15:0] sat_dac(input logic signed [ACC_W-1:0] v);
    if (v < $signed({3'b000, DAC_MIN})) return DAC_MIN;
    if (v > $signed({3'b000, DAC_MAX})) return DAC_MAX;
    return v[15:0];
  endfunction

  state_t      state, state_n, target, target_n;
  logic        pps_rise, rdy_rise;
  logic        skip, skip_n;
  logic [7:0]  lock_cnt, lock_cnt_n;
  logic [31:0] presc;
  logic [9:0]  tick_cnt;
  logic        timer_clr, timeout;
  logic        in_meas, meas_evt;
  logic [15:0] dac_n;
  logic        load_n;

  logic [15:0] diff_p0;
  logic        vld_p0;

  logic signed [ERR_W-1:0] err;
  logic signed [ACC_W-1:0] err_x, corr_c, corr_f, dac_ext;
  logic [15:0]             dac_coarse, dac_fine;
  logic                    in_bound, out_bound;

  sync_rise u_pps_sync (.clk(CLK), .rst(RST), .din(PPS), .rise(pps_rise));
  sync_rise u_rdy_sync (.clk(CLK), .rst(RST), .din(RDY), .rise(rdy_rise));

  assign in_meas  = (state == ST_ACQUIRE) || (state == ST_TRACK);
  assign meas_evt = rdy_rise && in_meas;
  assign timeout  = tick_cnt >= ({2'b00, MULT} + 10'd3);

  // Stage p0 -> p1: error, correction and saturated DAC candidates from the captured DIFF
  assign err        = $signed({1'b0, diff_p0}) - $signed({1'b0, DIFF_ZERO});
  assign err_x      = $signed({{(ACC_W-ERR_W){err[ERR_W-1]}}, err});
  assign corr_c     = err_x <<< KC_SHIFT;
  assign corr_f     = err_x >>> KF_SHIFT;
  assign dac_ext    = $signed({3'b000, DAC_WORD});
  assign dac_coarse = sat_dac(dac_ext - corr_c);
  assign dac_fine   = sat_dac(dac_ext - corr_f);
  assign in_bound   = (err >= LOCK_NEG) && (err <= LOCK_POS);
  assign out_bound  = (err > UNLOCK_POS) || (err < UNLOCK_NEG);

  always_comb begin
    state_n    = state;
    target_n   = target;
    skip_n     = skip;
    lock_cnt_n = lock_cnt;
    dac_n      = DAC_WORD;
    load_n     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (ENABLE && PPS_VALID) begin
          state_n  = ST_CLEAR;
          target_n = ST_ACQUIRE;
        end
      end
      ST_CLEAR: begin
        if (pps_rise) begin
          state_n = target;
          skip_n  = 1'b1;
        end else if (tick_cnt >= CLR_TICKS) begin
          state_n = ST_HOLDOVER;
        end
      end
      ST_ACQUIRE: begin
        if (timeout) begin
          state_n = ST_HOLDOVER;
        end else if (vld_p0) begin
          dac_n  = dac_coarse;
          load_n = 1'b1;
          if (in_bound) begin
            lock_cnt_n = lock_cnt + 8'd1;
            if (lock_cnt + 8'd1 >= LOCK_N) begin
              state_n  = ST_CLEAR;
              target_n = ST_TRACK;
            end
          end else begin
            lock_cnt_n = 8'd0;
          end
        end
      end
      ST_TRACK: begin
        if (timeout) begin
          state_n = ST_HOLDOVER;
        end else if (vld_p0) begin
          // A measurement that unlocks must not also steer the DAC.
          if (out_bound) begin
            state_n  = ST_CLEAR;
            target_n = ST_ACQUIRE;
          end else begin
            dac_n  = dac_fine;
            load_n = 1'b1;
          end
        end
      end
      ST_HOLDOVER: begin
        if (PPS_VALID && (tick_cnt >= HOLD_TICKS)) begin
          state_n  = ST_CLEAR;
          target_n = ST_ACQUIRE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (meas_evt && skip) skip_n = 1'b0;

    if (!ENABLE) begin
      state_n = ST_IDLE;
      dac_n   = DAC_WORD;
      load_n  = 1'b0;
    end else if (!PPS_VALID && (in_meas || (state == ST_CLEAR))) begin
      state_n = ST_HOLDOVER;
      dac_n   = DAC_WORD;
      load_n  = 1'b0;
    end

    if (state_n != ST_ACQUIRE) lock_cnt_n = 8'd0;
  end

  assign timer_clr = (state_n != state) || meas_evt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc    <= 32'd0;
      tick_cnt <= 10'd0;
    end else if (timer_clr) begin
      presc    <= 32'd0;
      tick_cnt <= 10'd0;
    end else if (presc == PRESC_MAX) begin
      presc <= 32'd0;
      if (tick_cnt != 10'h3FF) tick_cnt <= tick_cnt + 10'd1;
    end else begin
      presc <= presc + 32'd1;
    end
  end

  // Stage p0: capture DIFF one cycle after a counted rdy_rise
  always_ff @(posedge CLK) begin
    if (meas_evt) diff_p0 <= DIFF;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      target   <= ST_ACQUIRE;
      skip     <= 1'b0;
      lock_cnt <= 8'd0;
      vld_p0   <= 1'b0;
      MULT     <= MULT_COARSE;
      RUN      <= 1'b0;
      CLR      <= 1'b1;
      LOCKED   <= 1'b0;
      DAC_WORD <= DAC_INIT;
      DAC_LOAD <= 1'b0;
    end else begin
      state    <= state_n;
      target   <= target_n;
      skip     <= skip_n;
      lock_cnt <= lock_cnt_n;
      vld_p0   <= meas_evt && !skip && (state_n == state);
      if ((state_n == ST_CLEAR) && (state != ST_CLEAR))
        MULT <= (target_n == ST_TRACK) ? MULT_FINE : MULT_COARSE;
      RUN      <= (state_n == ST_CLEAR) || (state_n == ST_ACQUIRE) || (state_n == ST_TRACK);
      CLR      <= (state_n == ST_IDLE) || (state_n == ST_CLEAR) || (state_n == ST_HOLDOVER);
      LOCKED   <= (state_n == ST_TRACK);
      // Stage p1: DAC word and load strobe
      DAC_WORD <= dac_n;
      DAC_LOAD <= load_n;
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_gpsdo_loop_ctrl.sv
// Scoreboard bench for gpsdo_loop_ctrl: expected DAC loads are queued at stimulus time
// and checked by a monitor whenever DAC_LOAD pulses.
module tb_gpsdo_loop_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_CLEAR = 3'd1, S_ACQ = 3'd2,
                         S_TRACK = 3'd3, S_HOLD = 3'd4;

  logic        clk, rst, enable, pps_valid, pps, rdy;
  logic [15:0] diff;
  logic        run, clr, dac_load, locked;
  logic [7:0]  mult;
  logic [15:0] dac_word;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] dac;
    int          at;
  } exp_t;
  exp_t exp_q[$];

  gpsdo_loop_ctrl #(.CLK_HZ(20)) dut (
    .CLK(clk), .RST(rst), .ENABLE(enable), .PPS_VALID(pps_valid), .PPS(pps),
    .DIFF(diff), .RDY(rdy), .RUN(run), .CLR(clr), .MULT(mult),
    .DAC_WORD(dac_word), .DAC_LOAD(dac_load), .LOCKED(locked), .STATE(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && dac_load) begin
      if (exp_q.size() == 0) begin
        check("unexpected_load", {16'h0, dac_word}, 32'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("dac_word", {16'h0, dac_word}, {16'h0, e.dac});
        check("load_cycle", cyc, e.at);
      end
    end
  end

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    int n = 0;
    while (state !== st && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {29'h0, state}, {29'h0, st});
  endtask

  task automatic pulse_pps();
    @(negedge clk) pps = 1'b1;
    repeat (3) @(negedge clk);
    pps = 1'b0;
  endtask

  task automatic send_rdy(input logic [15:0] d, input bit load, input logic [15:0] dac_exp);
    exp_t e;
    @(negedge clk) diff = d;
    @(negedge clk) rdy = 1'b1;
    if (load) begin
      e.dac = dac_exp;
      e.at  = cyc + 5;
      exp_q.push_back(e);
    end
    repeat (3) @(negedge clk);
    rdy = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] dexp;
    rst = 1'b1; enable = 1'b1; pps_valid = 1'b1; pps = 1'b0; rdy = 1'b0; diff = 16'h7FFF;
    repeat (3) @(negedge clk);
    check("rst_state", {29'h0, state}, S_IDLE);
    check("rst_run", {31'h0, run}, 0);
    check("rst_clr", {31'h0, clr}, 1);
    check("rst_mult", {24'h0, mult}, 0);
    check("rst_dac", {16'h0, dac_word}, 32'h8000);
    check("rst_load", {31'h0, dac_load}, 0);
    check("rst_locked", {31'h0, locked}, 0);

    rst = 1'b0;
    @(negedge clk);
    check("enter_clear", {29'h0, state}, S_CLEAR);
    check("clear_run", {31'h0, run}, 1);
    check("clear_clr", {31'h0, clr}, 1);

    pulse_pps();
    wait_state(S_ACQ, 10, "to_acquire");
    check("acq_clr", {31'h0, clr}, 0);
    check("acq_mult", {24'h0, mult}, 0);

    // First measurement after CLEAR is discarded
    send_rdy(16'h8009, 1'b0, 16'h0);
    check("skip_dac", {16'h0, dac_word}, 32'h8000);
    send_rdy(16'h8009, 1'b1, 16'h7FD8);

    dexp = 16'h7FD8;
    for (int i = 0; i < 8; i++) begin
      dexp = dexp - 16'd4;
      send_rdy(16'h8000, 1'b1, dexp);
    end
    wait_state(S_CLEAR, 5, "lock_to_clear");
    check("fine_mult", {24'h0, mult}, 15);
    check("clear_unlocked", {31'h0, locked}, 0);

    pulse_pps();
    wait_state(S_TRACK, 10, "to_track");
    check("track_locked", {31'h0, locked}, 1);
    check("track_clr", {31'h0, clr}, 0);
    send_rdy(16'h7FFF, 1'b0, 16'h0);
    send_rdy(16'h7FFB, 1'b1, 16'h7FBA);

    // err=+22 unlocks without steering
    send_rdy(16'h8015, 1'b0, 16'h0);
    check("unlock_dac", {16'h0, dac_word}, 32'h7FBA);
    wait_state(S_CLEAR, 5, "unlock_to_clear");
    check("unlock_locked", {31'h0, locked}, 0);
    check("unlock_mult", {24'h0, mult}, 0);

    pulse_pps();
    wait_state(S_ACQ, 10, "reacquire");
    send_rdy(16'h7FFF, 1'b0, 16'h0);
    send_rdy(16'h9FED, 1'b1, 16'h0002);
    send_rdy(16'h8063, 1'b1, 16'h0000);
    send_rdy(16'h0000, 1'b1, 16'hFFFF);
    send_rdy(16'hFFFF, 1'b1, 16'h0000);

    repeat (30) @(negedge clk);
    check("no_early_timeout", {29'h0, state}, S_ACQ);
    wait_state(S_HOLD, 60, "timeout_holdover");
    check("hold_run", {31'h0, run}, 0);
    check("hold_clr", {31'h0, clr}, 1);
    check("hold_dac", {16'h0, dac_word}, 32'h0000);
    wait_state(S_CLEAR, 40, "hold_to_clear");

    pulse_pps();
    wait_state(S_ACQ, 10, "acq_again");
    send_rdy(16'h7FFF, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++) send_rdy(16'h7FFF, 1'b1, 16'h0000);
    wait_state(S_CLEAR, 5, "relock_clear");
    pulse_pps();
    wait_state(S_TRACK, 10, "retrack");
    send_rdy(16'h7FFF, 1'b0, 16'h0);
    send_rdy(16'h7FF5, 1'b1, 16'h0005);

    @(negedge clk) pps_valid = 1'b0;
    @(negedge clk);
    check("ppsv_drop_state", {29'h0, state}, S_HOLD);
    check("ppsv_drop_run", {31'h0, run}, 0);
    check("ppsv_drop_locked", {31'h0, locked}, 0);
    send_rdy(16'h8009, 1'b0, 16'h0);
    check("hold_frozen", {16'h0, dac_word}, 32'h0005);

    pps_valid = 1'b1;
    wait_state(S_CLEAR, 40, "hold_rearm");
    pulse_pps();
    wait_state(S_ACQ, 10, "acq_third");
    send_rdy(16'h7FFF, 1'b0, 16'h0);
    send_rdy(16'h7FF5, 1'b1, 16'h002D);

    // ENABLE low outranks PPS_VALID low
    @(negedge clk) begin enable = 1'b0; pps_valid = 1'b0; end
    @(negedge clk);
    check("disable_state", {29'h0, state}, S_IDLE);
    check("disable_dac", {16'h0, dac_word}, 32'h002D);
    check("disable_clr", {31'h0, clr}, 1);

    enable = 1'b1; pps_valid = 1'b1;
    wait_state(S_CLEAR, 5, "reenable");
    pulse_pps();
    wait_state(S_ACQ, 10, "acq_before_rst");
    @(negedge clk) rst = 1'b1;
    #1;
    check("midrst_dac", {16'h0, dac_word}, 32'h8000);
    check("midrst_state", {29'h0, state}, S_IDLE);
    check("midrst_run", {31'h0, run}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
